// File: rtl/conv_layer_pkg.sv
// Shared encodings and geometry defaults for the conv layer input path.
package conv_layer_pkg;

  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_KERNEL_SIZE = 3;
  localparam int unsigned DEF_IMAGE_SIZE  = 8;
  localparam int unsigned DEF_ARRAY_SIZE  = 6;
  localparam int unsigned DEF_ADDR_WIDTH  = 6;
  localparam int unsigned DEF_ROM_DEPTH   = 64;

  typedef enum logic [1:0] {
    CMD_IDLE          = 2'd0,
    CMD_PRELOAD_START = 2'd1,
    CMD_SHIFT_START   = 2'd2,
    CMD_LOAD_START    = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ACK_IDLE        = 2'd0,
    ACK_PRELOAD_FIN = 2'd1,
    ACK_SHIFT_FIN   = 2'd2,
    ACK_LOAD_FIN    = 2'd3
  } ack_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LAST  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/conv_input_interface_if.sv
// Controller, image ROM and kernel-array window signals of conv_input_interface.
// frame_done exists only when CONV_INPUT_FRAME_DONE_EN is defined.
interface conv_input_interface_if #(
  parameter int unsigned WIDTH      = conv_layer_pkg::DEF_WIDTH,
  parameter int unsigned ARRAY_SIZE = conv_layer_pkg::DEF_ARRAY_SIZE,
  parameter int unsigned ADDR_WIDTH = conv_layer_pkg::DEF_ADDR_WIDTH
);
  logic [1:0]                  cmd;
  logic [1:0]                  ack;
  logic [ADDR_WIDTH-1:0]       rom_addr;
  logic [WIDTH-1:0]            rom_data;
  logic [ARRAY_SIZE*WIDTH-1:0] out_data;
  logic                        out_valid;
`ifdef CONV_INPUT_FRAME_DONE_EN
  logic                        frame_done;

  modport master (output cmd, rom_data,
                  input  ack, rom_addr, out_data, out_valid, frame_done);
  modport slave  (input  cmd, rom_data,
                  output ack, rom_addr, out_data, out_valid, frame_done);
`else
  modport master (output cmd, rom_data,
                  input  ack, rom_addr, out_data, out_valid);
  modport slave  (input  cmd, rom_data,
                  output ack, rom_addr, out_data, out_valid);
`endif
endinterface

// File: rtl/conv_row_buffer.sv
// Image row buffer: indexed write, shift toward word 0 with zero fill, parallel read.
module conv_row_buffer #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   shift_en,
  output logic [DEPTH*WIDTH-1:0] rd_data
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end else if (shift_en) begin
      mem <= {WIDTH'(0), mem[DEPTH-1:1]};
    end
  end

  assign rd_data = mem;
endmodule

// File: rtl/conv_input_interface.sv
// Executes preload/shift/load commands: fetches image rows from ROM into a row buffer and
// presents sliding windows. Optional frame_done output enabled by CONV_INPUT_FRAME_DONE_EN.
module conv_input_interface
  import conv_layer_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int unsigned IMAGE_SIZE  = DEF_IMAGE_SIZE,
  parameter int unsigned ARRAY_SIZE  = DEF_ARRAY_SIZE,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned ROM_DEPTH   = DEF_ROM_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv_input_interface_if.slave  bus
);
  localparam int unsigned      COL_W    = $clog2(IMAGE_SIZE);
  localparam int unsigned      AW1      = ADDR_WIDTH + 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_SIZE - 1);
  localparam logic [COL_W-1:0] LAST_K   = COL_W'(KERNEL_SIZE - 1);
  localparam logic [COL_W-1:0] LAST_OUT = COL_W'(ARRAY_SIZE - 1);

  if (ROM_DEPTH != IMAGE_SIZE * IMAGE_SIZE || ARRAY_SIZE != IMAGE_SIZE - KERNEL_SIZE + 1)
  begin : g_bad_geometry
    $error("conv_input_interface: inconsistent geometry parameters");
  end

  state_e                      state, state_d;
  logic [1:0]                  op, op_d;
  logic [COL_W-1:0]            out_row, out_row_d, k_row, k_row_d, col, col_d, wr_col;
  logic                        wr_vld;
  logic                        shift_en_c;
  logic [1:0]                  ack_d;
  logic [ADDR_WIDTH-1:0]       rom_addr_d;
  logic                        out_valid_d;
  logic [ARRAY_SIZE*WIDTH-1:0] out_data_d;
  logic [IMAGE_SIZE*WIDTH-1:0] row_q;
`ifdef CONV_INPUT_FRAME_DONE_EN
  logic                        wrapped, wrapped_d, frame_done_d;
`endif

  // Address math widened by one bit, then truncated to the ROM port.
  function automatic logic [ADDR_WIDTH-1:0] fetch_addr(input logic [COL_W-1:0] o,
                                                       input logic [COL_W-1:0] k,
                                                       input logic [COL_W-1:0] c);
    logic [AW1-1:0] a;
    a = (AW1'(o) + AW1'(k)) * AW1'(IMAGE_SIZE) + AW1'(c);
    return a[ADDR_WIDTH-1:0];
  endfunction

  conv_row_buffer #(.WIDTH(WIDTH), .DEPTH(IMAGE_SIZE)) u_row_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_vld),
    .wr_idx   (wr_col),
    .wr_data  (bus.rom_data),
    .shift_en (shift_en_c),
    .rd_data  (row_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      op            <= CMD_IDLE;
      out_row       <= '0;
      k_row         <= '0;
      col           <= '0;
      wr_col        <= '0;
      wr_vld        <= 1'b0;
      bus.ack       <= ACK_IDLE;
      bus.rom_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
`ifdef CONV_INPUT_FRAME_DONE_EN
      wrapped        <= 1'b0;
      bus.frame_done <= 1'b0;
`endif
    end else begin
      state         <= state_d;
      op            <= op_d;
      out_row       <= out_row_d;
      k_row         <= k_row_d;
      col           <= col_d;
      wr_col        <= col;
      wr_vld        <= (state == ST_FETCH);
      bus.ack       <= ack_d;
      bus.rom_addr  <= rom_addr_d;
      bus.out_valid <= out_valid_d;
      bus.out_data  <= out_data_d;
`ifdef CONV_INPUT_FRAME_DONE_EN
      wrapped        <= wrapped_d;
      bus.frame_done <= frame_done_d;
`endif
    end
  end

  always_comb begin
    state_d     = state;
    op_d        = op;
    out_row_d   = out_row;
    k_row_d     = k_row;
    col_d       = col;
    shift_en_c  = 1'b0;
    ack_d       = ACK_IDLE;
    rom_addr_d  = bus.rom_addr;
    out_valid_d = 1'b0;
    out_data_d  = bus.out_data;
`ifdef CONV_INPUT_FRAME_DONE_EN
    wrapped_d    = wrapped;
    frame_done_d = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        case (bus.cmd)
          CMD_PRELOAD_START: begin
            op_d       = bus.cmd;
            out_row_d  = '0;
            k_row_d    = '0;
            col_d      = '0;
            rom_addr_d = fetch_addr('0, '0, '0);
            state_d    = ST_FETCH;
`ifdef CONV_INPUT_FRAME_DONE_EN
            wrapped_d  = 1'b0;
`endif
          end
          CMD_SHIFT_START: begin
            op_d        = bus.cmd;
            out_valid_d = 1'b1;
            out_data_d  = row_q[ARRAY_SIZE*WIDTH-1:0];
            state_d     = ST_SHIFT;
          end
          CMD_LOAD_START: begin
            op_d = bus.cmd;
`ifdef CONV_INPUT_FRAME_DONE_EN
            wrapped_d = 1'b0;
`endif
            // Step down the kernel rows, then move to the next output row.
            if (k_row < LAST_K) begin
              k_row_d = k_row + COL_W'(1);
            end else begin
              k_row_d = '0;
              if (out_row == LAST_OUT) begin
                out_row_d = '0;
`ifdef CONV_INPUT_FRAME_DONE_EN
                wrapped_d = 1'b1;
`endif
              end else begin
                out_row_d = out_row + COL_W'(1);
              end
            end
            col_d      = '0;
            rom_addr_d = fetch_addr(out_row_d, k_row_d, '0);
            state_d    = ST_FETCH;
          end
          default: ;
        endcase
      end
      ST_FETCH: begin
        if (col == LAST_COL) begin
          state_d = ST_LAST;
        end else begin
          col_d      = col + COL_W'(1);
          rom_addr_d = fetch_addr(out_row, k_row, col_d);
        end
      end
      ST_LAST: begin
        state_d = ST_DONE;
        ack_d   = (op == CMD_LOAD_START) ? ACK_LOAD_FIN : ACK_PRELOAD_FIN;
`ifdef CONV_INPUT_FRAME_DONE_EN
        frame_done_d = (op == CMD_LOAD_START) && wrapped;
`endif
      end
      ST_SHIFT: begin
        shift_en_c = 1'b1;
        ack_d      = ACK_SHIFT_FIN;
        state_d    = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_conv_input_interface.sv
// Self-checking bench for conv_input_interface: command table plus reset/ignore/frame sequences.
module tb_conv_input_interface;
  import conv_layer_pkg::*;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned IMAGE_SIZE  = 8;
  localparam int unsigned ARRAY_SIZE  = 6;
  localparam int unsigned ADDR_WIDTH  = 6;
  localparam int unsigned ROM_DEPTH   = 64;
  localparam int unsigned CW          = ARRAY_SIZE * WIDTH;
  localparam int          NVEC        = 13;

  typedef struct {
    logic [1:0] cmd;
    logic [1:0] ack;
    int         base;
    int         w_first;
    int         w_nz;
  } vec_t;

  typedef struct {
    logic [CW-1:0] data;
    int            due;
  } win_rec_t;

  typedef struct {
    logic [1:0] ack;
    int         due;
    logic       fd;
  } ack_rec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_valid = 0;
  int   n_ack = 0;
  int   n_fd = 0;

  win_rec_t win_q[$];
  ack_rec_t ack_q[$];
  vec_t     vecs[NVEC];

  conv_input_interface_if #(.WIDTH(WIDTH), .ARRAY_SIZE(ARRAY_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  conv_input_interface #(
    .WIDTH(WIDTH), .KERNEL_SIZE(KERNEL_SIZE), .IMAGE_SIZE(IMAGE_SIZE),
    .ARRAY_SIZE(ARRAY_SIZE), .ADDR_WIDTH(ADDR_WIDTH), .ROM_DEPTH(ROM_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous image ROM with ROM[a] = a.
  always @(posedge clk) bus.rom_data <= WIDTH'(bus.rom_addr);

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_win(input int first, input int nz);
    logic [CW-1:0] w;
    w = '0;
    for (int j = 0; j < int'(ARRAY_SIZE); j++)
      if (j < nz) w[j*WIDTH +: WIDTH] = WIDTH'(first + j);
    return w;
  endfunction

  // Output monitor: pops scoreboard entries when the DUT produces a window or an ack.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        n_valid++;
        if (win_q.size() == 0) begin
          check("unexpected_out_valid", CW'(bus.out_valid), CW'(0));
        end else begin
          win_rec_t w;
          w = win_q.pop_front();
          check("window", bus.out_data, w.data);
          check("window_cycle", CW'(cyc), CW'(w.due));
        end
      end
      if (bus.ack != ACK_IDLE) begin
        n_ack++;
        if (ack_q.size() == 0) begin
          check("unexpected_ack", CW'(bus.ack), CW'(ACK_IDLE));
        end else begin
          ack_rec_t a;
          a = ack_q.pop_front();
          check("ack", CW'(bus.ack), CW'(a.ack));
          check("ack_cycle", CW'(cyc), CW'(a.due));
`ifdef CONV_INPUT_FRAME_DONE_EN
          check("frame_done", CW'(bus.frame_done), CW'(a.fd));
`endif
        end
      end
`ifdef CONV_INPUT_FRAME_DONE_EN
      if (bus.frame_done) n_fd++;
      if (bus.frame_done && bus.ack == ACK_IDLE)
        check("frame_done_stray", CW'(bus.frame_done), CW'(0));
`endif
    end
  end

  // Issue one command at a negedge (cycle c0) and walk it to the following idle cycle.
  task automatic run_cmd(input logic [1:0] c, input logic [1:0] exp_ack, input int base,
                         input logic [CW-1:0] win, input logic fd);
    int       c0;
    bit       fetch;
    win_rec_t w;
    ack_rec_t a;
    c0    = cyc;
    fetch = (c != CMD_SHIFT_START);
    if (!fetch) begin
      w.data = win;
      w.due  = c0 + 1;
      win_q.push_back(w);
    end
    a.ack = exp_ack;
    a.due = c0 + (fetch ? int'(IMAGE_SIZE) + 2 : 2);
    a.fd  = fd;
    ack_q.push_back(a);
    bus.cmd = c;
    @(negedge clk);
    bus.cmd = CMD_IDLE;
    if (fetch) begin
      for (int k = 0; k < int'(IMAGE_SIZE); k++) begin
        check("rom_addr", CW'(bus.rom_addr), CW'(base + k));
        @(negedge clk);
      end
    end else begin
      @(negedge clk);
      check("out_data_hold", bus.out_data, win);
      check("out_valid_drop", CW'(bus.out_valid), CW'(0));
    end
    while (cyc < c0 + (fetch ? int'(IMAGE_SIZE) + 3 : 3)) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, v0, a0, f0, mo, mk;

    rst_n   = 1'b0;
    bus.cmd = CMD_IDLE;
    repeat (2) @(negedge clk);
    check("reset_ack", CW'(bus.ack), CW'(0));
    check("reset_out_valid", CW'(bus.out_valid), CW'(0));
    check("reset_out_data", bus.out_data, CW'(0));
    check("reset_rom_addr", CW'(bus.rom_addr), CW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0]  = '{CMD_PRELOAD_START, ACK_PRELOAD_FIN, 0,  0, 0};
    vecs[1]  = '{CMD_SHIFT_START,   ACK_SHIFT_FIN,   0,  0, 6};
    vecs[2]  = '{CMD_SHIFT_START,   ACK_SHIFT_FIN,   0,  1, 6};
    vecs[3]  = '{CMD_SHIFT_START,   ACK_SHIFT_FIN,   0,  2, 6};
    vecs[4]  = '{CMD_SHIFT_START,   ACK_SHIFT_FIN,   0,  3, 5};
    vecs[5]  = '{CMD_LOAD_START,    ACK_LOAD_FIN,    8,  0, 0};
    vecs[6]  = '{CMD_SHIFT_START,   ACK_SHIFT_FIN,   0,  8, 6};
    vecs[7]  = '{CMD_LOAD_START,    ACK_LOAD_FIN,    16, 0, 0};
    vecs[8]  = '{CMD_LOAD_START,    ACK_LOAD_FIN,    8,  0, 0};
    vecs[9]  = '{CMD_SHIFT_START,   ACK_SHIFT_FIN,   0,  8, 6};
    vecs[10] = '{CMD_LOAD_START,    ACK_LOAD_FIN,    16, 0, 0};
    vecs[11] = '{CMD_PRELOAD_START, ACK_PRELOAD_FIN, 0,  0, 0};
    vecs[12] = '{CMD_SHIFT_START,   ACK_SHIFT_FIN,   0,  0, 6};

    for (int i = 0; i < NVEC; i++)
      run_cmd(vecs[i].cmd, vecs[i].ack, vecs[i].base, mk_win(vecs[i].w_first, vecs[i].w_nz), 1'b0);

    // A shift issued mid-fetch must be dropped.
    v0 = n_valid;
    a0 = n_ack;
    c0 = cyc;
    begin
      ack_rec_t a;
      a.ack = ACK_PRELOAD_FIN;
      a.due = c0 + int'(IMAGE_SIZE) + 2;
      a.fd  = 1'b0;
      ack_q.push_back(a);
    end
    bus.cmd = CMD_PRELOAD_START;
    @(negedge clk);
    bus.cmd = CMD_IDLE;
    while (cyc < c0 + 4) @(negedge clk);
    bus.cmd = CMD_SHIFT_START;
    @(negedge clk);
    bus.cmd = CMD_IDLE;
    while (cyc < c0 + int'(IMAGE_SIZE) + 3) @(negedge clk);
    check("ignored_cmd_valid_count", CW'(n_valid), CW'(v0));
    check("ignored_cmd_ack_count", CW'(n_ack), CW'(a0 + 1));
    run_cmd(CMD_SHIFT_START, ACK_SHIFT_FIN, 0, mk_win(0, 6), 1'b0);

    // Reset in the middle of a fetch aborts it without an ack.
    a0 = n_ack;
    c0 = cyc;
    bus.cmd = CMD_PRELOAD_START;
    @(negedge clk);
    bus.cmd = CMD_IDLE;
    while (cyc < c0 + 5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_ack", CW'(bus.ack), CW'(0));
    check("abort_out_valid", CW'(bus.out_valid), CW'(0));
    check("abort_out_data", bus.out_data, CW'(0));
    check("abort_rom_addr", CW'(bus.rom_addr), CW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_ack", CW'(n_ack), CW'(a0));
    run_cmd(CMD_SHIFT_START, ACK_SHIFT_FIN, 0, mk_win(0, 0), 1'b0);
    run_cmd(CMD_PRELOAD_START, ACK_PRELOAD_FIN, 0, '0, 1'b0);
    run_cmd(CMD_SHIFT_START, ACK_SHIFT_FIN, 0, mk_win(0, 6), 1'b0);

`ifdef CONV_INPUT_FRAME_DONE_EN
    // Eighteen loads walk every kernel row of every output row and wrap to row 0.
    run_cmd(CMD_PRELOAD_START, ACK_PRELOAD_FIN, 0, '0, 1'b0);
    f0 = n_fd;
    mo = 0;
    mk = 0;
    for (int i = 1; i <= 18; i++) begin
      if (mk < int'(KERNEL_SIZE) - 1) mk++;
      else begin
        mk = 0;
        mo = (mo == int'(ARRAY_SIZE) - 1) ? 0 : mo + 1;
      end
      run_cmd(CMD_LOAD_START, ACK_LOAD_FIN, (mo + mk) * int'(IMAGE_SIZE), '0, (i == 18));
    end
    check("frame_done_count", CW'(n_fd - f0), CW'(1));
`else
    f0 = 0;
    mo = 0;
    mk = 0;
`endif

    repeat (3) @(negedge clk);
    check("pending_windows", CW'(win_q.size()), CW'(0));
    check("pending_acks", CW'(ack_q.size()), CW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
